cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Synthesizable run monitor for the single-cycle CPU. Sits beside the datapath
//  and taps its PC, instruction and store bus. Counts cycles and retired
//  instructions, and detects the end sentinel or a cycle timeout. Tracks
//  NUM_CHK expected store checkpoints and flags misaligned stores.
//  Replaces bench-only checking, so on-chip runs report pass/fail and CPI data.
// PARAMETERS
//  MAX_CYCLES    20            run cycles before TIMEOUT (>=1)
//  END_SENTINEL  32'h0000_006F instruction ending the run (jal x0,0)
//  NUM_CHK       2             number of store checkpoints (>=1)
//  CHK_ADDR      {NUM_CHK{32'h20}}  packed NUM_CHK*32 byte addrs; chk i = [32*i+:32]
//  CHK_DATA      {NUM_CHK{32'h000C08EB}} packed NUM_CHK*32 expected store data
//  CNT_W         32            width of cycle/instr counters
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low (0 = reset)
//  start        in   1        1-cycle pulse; IDLE->RUN
//  clear        in   1        synchronous return to IDLE, clears all state
//  instr_valid  in   1        instruction retires this cycle
//  pc           in   32       PC of retiring instruction
//  instr        in   32       retiring instruction word
//  mem_write    in   1        store strobe
//  dmem_addr    in   32       store byte address
//  wdata        in   32       store data
//  busy         out  1        state==RUN
//  done         out  1        state==DONE (sentinel reached)
//  timeout      out  1        state==TIMEOUT
//  pass         out  1        done & (&chk_pass) & ~misalign
//  chk_pass     out  NUM_CHK  per-checkpoint status
//  misalign     out  1        sticky: any misaligned store seen in RUN
//  misalign_cnt out  8        misaligned store count, saturates at 8'hFF
//  misalign_addr out 32       address of first misaligned store
//  end_pc       out  32       PC of sentinel instruction
//  cycle_count  out  CNT_W    RUN cycles elapsed
//  instr_count  out  CNT_W    instructions retired in RUN
// BEHAVIOUR
//  - Reset (reset=0) or clear=1: state IDLE; every output and register is 0.
//    Reset is async; clear is sync. Mid-run reset or clear abandons the run.
//  - FSM IDLE->RUN on start; RUN->DONE or ->TIMEOUT. DONE/TIMEOUT hold until
//    clear/reset; start is ignored outside IDLE.
//  - In RUN, every edge: cycle_count+1; instr_count+1 if instr_valid. Both
//    include the sentinel cycle. Counters freeze outside RUN. CPI = cycle/instr,
//    computed by software.
//  - Sentinel: instr_valid & instr==END_SENTINEL in RUN -> next state DONE;
//    end_pc<=pc. This is registered, so done rises 1 cycle after the sentinel.
//  - Timeout: in RUN, if cycle_count==MAX_CYCLES-1 and no sentinel that cycle,
//    then cycle_count<=MAX_CYCLES and state<=TIMEOUT. A sentinel in that same
//    cycle wins and the state goes to DONE.
//  - Stores are examined only in RUN when mem_write=1.
//    - Misaligned (dmem_addr[1:0]!=0): misalign<=1, misalign_cnt+1 (saturating).
//      misalign_addr is latched only on the first one. Checkpoints not updated.
//    - Aligned: for each i with dmem_addr[31:2]==CHK_ADDR_i[31:2], set
//      chk_pass[i]<=(wdata==CHK_DATA_i). Last store to the address wins, like a
//      memory value. Several checkpoints may match one store; all update.
//  - pass is combinational from registered state; 0 in TIMEOUT.
//  - Inputs are ignored in IDLE/DONE/TIMEOUT. A sentinel on the start cycle is
//    not counted, because the state is still IDLE.
// TESTING
//  1 Defaults, start; 5 retiring instrs, store 0x20<-000C08EB on the 3rd, sentinel
//    on the 5th -> done=1, pass=1, cycle_count=5, instr_count=5, end_pc=sentinel PC.
//  2 No sentinel, MAX_CYCLES=20 -> timeout=1 after 20 RUN cycles, cycle_count=20,
//    pass=0; sentinel on cycle 20 instead -> done=1.
//  3 Store 0x20<-000C08EB, then 0x20<-0 -> chk_pass[0]=0; then 0x22<-x (misaligned)
//    -> misalign=1, misalign_addr=0x22, chk_pass unchanged.
//  4 300 misaligned stores -> misalign_cnt=FF, misalign_addr=first address.
//  5 Async reset low mid-RUN (between edges) -> all outputs 0 immediately;
//    clear in DONE -> IDLE, counters 0, start accepted next cycle.
//  6 NUM_CHK=3 with distinct addrs; match 2 of 3 then sentinel -> chk_pass=3'b011,
//    done=1, pass=0.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Purpose: on-chip run monitor for the single-cycle CPU; counts cycles/retires, detects end sentinel or timeout, checks store checkpoints.
// Latency: status registered; done/timeout rise one clock after the deciding cycle, pass is a decode of registered state.
// Backpressure: none; passive tap of the datapath, never stalls the CPU.
module cpu_run_monitor #(
  parameter int                    MAX_CYCLES   = 20,
  parameter logic [31:0]           END_SENTINEL = 32'h0000_006F,
  parameter int                    NUM_CHK      = 2,
  parameter logic [NUM_CHK*32-1:0] CHK_ADDR     = {NUM_CHK{32'h0000_0020}},
  parameter logic [NUM_CHK*32-1:0] CHK_DATA     = {NUM_CHK{32'h000C_08EB}},
  parameter int                    CNT_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic [31:0]        instr,
  input  logic               mem_write,
  input  logic [31:0]        dmem_addr,
  input  logic [31:0]        wdata,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               pass,
  output logic [NUM_CHK-1:0] chk_pass,
  output logic               misalign,
  output logic [7:0]         misalign_cnt,
  output logic [31:0]        misalign_addr,
  output logic [31:0]        end_pc,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  // Last RUN cycle index before the run is declared hung.
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] FINAL_CYC = CNT_W'(MAX_CYCLES);

  state_t state;
  logic   sentinel;
  logic   store_en;

  assign sentinel = instr_valid && (instr == END_SENTINEL);
  assign store_en = (state == S_RUN) && mem_write;

  // Run FSM with registered status flags, counters and sentinel PC capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      end_pc      <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      end_pc      <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A sentinel coinciding with start is not part of the run.
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (instr_valid) instr_count <= instr_count + CNT_W'(1);
          // Sentinel takes priority over a timeout landing on the same cycle.
          if (sentinel) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            end_pc <= pc;
          end else if (cycle_count == LAST_CYC) begin
            state       <= S_TIMEOUT;
            busy        <= 1'b0;
            timeout     <= 1'b1;
            cycle_count <= FINAL_CYC;
          end
        end
        default: begin
          // DONE and TIMEOUT hold until clear or reset.
          state <= state;
        end
      endcase
    end
  end

  // Store observation: sticky misalignment tracking and last-write-wins checkpoints.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign      <= 1'b0;
      misalign_cnt  <= 8'd0;
      misalign_addr <= 32'd0;
      chk_pass      <= '0;
    end else if (clear) begin
      misalign      <= 1'b0;
      misalign_cnt  <= 8'd0;
      misalign_addr <= 32'd0;
      chk_pass      <= '0;
    end else if (store_en) begin
      if (dmem_addr[1:0] != 2'b00) begin
        misalign <= 1'b1;
        if (misalign_cnt != 8'hFF) misalign_cnt <= misalign_cnt + 8'd1;
        if (!misalign) misalign_addr <= dmem_addr;
      end else begin
        for (int i = 0; i < NUM_CHK; i++) begin
          if (dmem_addr[31:2] == CHK_ADDR[32*i+2 +: 30]) begin
            chk_pass[i] <= (wdata == CHK_DATA[32*i +: 32]);
          end
        end
      end
    end
  end

  // Overall verdict only meaningful once the sentinel has been reached.
  assign pass = done & (&chk_pass) & ~misalign;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Purpose: directed bench for cpu_run_monitor with a queue-based scoreboard of expected values.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_cpu_run_monitor;

  logic        clk;
  logic        reset;
  logic        start;
  logic        clear;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        mem_write;
  logic [31:0] dmem_addr;
  logic [31:0] wdata;

  logic        busy, done, timeout, pass, misalign;
  logic [1:0]  chk_pass;
  logic [7:0]  misalign_cnt;
  logic [31:0] misalign_addr, end_pc, cycle_count, instr_count;

  logic        busy3, done3, timeout3, pass3, misalign3;
  logic [2:0]  chk_pass3;
  logic [7:0]  misalign_cnt3;
  logic [31:0] misalign_addr3, end_pc3, cycle_count3, instr_count3;

  localparam logic [31:0] SENT = 32'h0000_006F;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] GOOD = 32'h000C_08EB;

  int tests = 0;
  int fails = 0;

  string       q_tag[$];
  logic [31:0] q_val[$];

  cpu_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .mem_write(mem_write), .dmem_addr(dmem_addr), .wdata(wdata),
    .busy(busy), .done(done), .timeout(timeout), .pass(pass),
    .chk_pass(chk_pass), .misalign(misalign), .misalign_cnt(misalign_cnt),
    .misalign_addr(misalign_addr), .end_pc(end_pc),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  cpu_run_monitor #(
    .MAX_CYCLES(1000),
    .NUM_CHK(3),
    .CHK_ADDR({32'h0000_0108, 32'h0000_0104, 32'h0000_0100}),
    .CHK_DATA({32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001})
  ) dut3 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .mem_write(mem_write), .dmem_addr(dmem_addr), .wdata(wdata),
    .busy(busy3), .done(done3), .timeout(timeout3), .pass(pass3),
    .chk_pass(chk_pass3), .misalign(misalign3), .misalign_cnt(misalign_cnt3),
    .misalign_addr(misalign_addr3), .end_pc(end_pc3),
    .cycle_count(cycle_count3), .instr_count(instr_count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic exp(input string tag, input logic [31:0] v);
    q_tag.push_back(tag);
    q_val.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests++;
    if (q_tag.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_val.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; clear = 1'b0; instr_valid = 1'b0; pc = 32'd0;
    instr = 32'd0; mem_write = 1'b0; dmem_addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] ins);
    instr_valid = 1'b1; pc = p; instr = ins; tick(); instr_valid = 1'b0; instr = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; dmem_addr = a; wdata = d; tick(); mem_write = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    // Reset state
    exp("rst_busy", 0);   chk(32'(busy));
    exp("rst_done", 0);   chk(32'(done));
    exp("rst_chk", 0);    chk(32'(chk_pass));
    exp("rst_cycles", 0); chk(cycle_count);
    tick();
    reset = 1'b1;
    tick();

    // Test 1: five retires, good store on 3rd, sentinel on 5th
    do_start();
    exp("t1_busy", 1); chk(32'(busy));
    retire(32'h100, NOP);
    retire(32'h104, NOP);
    mem_write = 1'b1; dmem_addr = 32'h20; wdata = GOOD;
    retire(32'h108, NOP);
    mem_write = 1'b0;
    retire(32'h10C, NOP);
    exp("t1_done_early", 0); chk(32'(done));
    retire(32'h110, SENT);
    exp("t1_done", 1);     chk(32'(done));
    exp("t1_busy_off", 0); chk(32'(busy));
    exp("t1_pass", 1);     chk(32'(pass));
    exp("t1_chk", 3);      chk(32'(chk_pass));
    exp("t1_cycles", 5);   chk(cycle_count);
    exp("t1_instrs", 5);   chk(instr_count);
    exp("t1_end_pc", 32'h110); chk(end_pc);
    retire(32'h114, NOP);
    do_start();
    exp("t1_freeze_cyc", 5); chk(cycle_count);
    exp("t1_freeze_ins", 5); chk(instr_count);
    exp("t1_hold_done", 1);  chk(32'(done));

    // Test 5b: clear in DONE returns to IDLE, start accepted next cycle
    do_clear();
    exp("t5_clr_done", 0);   chk(32'(done));
    exp("t5_clr_cyc", 0);    chk(cycle_count);
    exp("t5_clr_ins", 0);    chk(instr_count);
    exp("t5_clr_endpc", 0);  chk(end_pc);
    exp("t5_clr_chk", 0);    chk(32'(chk_pass));
    do_start();
    exp("t5_restart_busy", 1); chk(32'(busy));

    // Test 2a: no sentinel -> timeout after 20 RUN cycles
    for (int i = 0; i < 19; i++) tick();
    exp("t2_not_yet", 0); chk(32'(timeout));
    exp("t2_cyc19", 19);  chk(cycle_count);
    tick();
    exp("t2_timeout", 1); chk(32'(timeout));
    exp("t2_cyc20", 20);  chk(cycle_count);
    exp("t2_pass", 0);    chk(32'(pass));
    exp("t2_busy", 0);    chk(32'(busy));
    tick(); tick();
    exp("t2_hold_cyc", 20); chk(cycle_count);

    // Test 2b: sentinel on the 20th cycle wins over timeout
    do_clear();
    do_start();
    for (int i = 0; i < 19; i++) tick();
    retire(32'h200, SENT);
    exp("t2b_done", 1);    chk(32'(done));
    exp("t2b_tmo", 0);     chk(32'(timeout));
    exp("t2b_cyc", 20);    chk(cycle_count);
    exp("t2b_ins", 1);     chk(instr_count);
    exp("t2b_endpc", 32'h200); chk(end_pc);

    // Sentinel on the start cycle is ignored
    do_clear();
    start = 1'b1; instr_valid = 1'b1; instr = SENT; pc = 32'h300;
    tick();
    start = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    exp("st_busy", 1); chk(32'(busy));
    exp("st_done", 0); chk(32'(done));
    exp("st_ins", 0);  chk(instr_count);

    // Test 3: last store wins, misaligned store leaves checkpoints alone
    store(32'h20, GOOD);
    exp("t3_good", 3); chk(32'(chk_pass));
    store(32'h20, 32'd0);
    exp("t3_bad", 0);  chk(32'(chk_pass));
    store(32'h20, GOOD);
    store(32'h22, 32'd0);
    exp("t3_chk_keep", 3);      chk(32'(chk_pass));
    exp("t3_misalign", 1);      chk(32'(misalign));
    exp("t3_maddr", 32'h22);    chk(misalign_addr);
    exp("t3_mcnt", 1);          chk(32'(misalign_cnt));

    // Test 4: 300 misaligned stores on the long-timeout instance
    do_clear();
    do_start();
    store(32'h1001, 32'd5);
    for (int i = 0; i < 253; i++) store(32'h2003, 32'd5);
    exp("t4_cnt254", 32'hFE); chk(32'(misalign_cnt3));
    store(32'h2003, 32'd5);
    exp("t4_cnt255", 32'hFF); chk(32'(misalign_cnt3));
    for (int i = 0; i < 45; i++) store(32'h2002, 32'd5);
    exp("t4_sat", 32'hFF);       chk(32'(misalign_cnt3));
    exp("t4_maddr", 32'h1001);   chk(misalign_addr3);
    exp("t4_cyc", 300);          chk(cycle_count3);
    exp("t4_busy", 1);           chk(32'(busy3));

    // Test 6: three checkpoints, two match, then sentinel
    do_clear();
    do_start();
    store(32'h100, 32'hAAAA_0001);
    store(32'h104, 32'hBBBB_0002);
    store(32'h108, 32'hDEAD_BEEF);
    retire(32'h400, SENT);
    exp("t6_chk", 3);      chk(32'(chk_pass3));
    exp("t6_done", 1);     chk(32'(done3));
    exp("t6_pass", 0);     chk(32'(pass3));
    exp("t6_misalign", 0); chk(32'(misalign3));

    // Test 5a: async reset between edges clears outputs immediately
    do_clear();
    do_start();
    retire(32'h500, NOP);
    store(32'h21, 32'd1);
    retire(32'h504, NOP);
    #3;
    reset = 1'b0;
    #1;
    exp("t5_ar_busy", 0); chk(32'(busy));
    exp("t5_ar_cyc", 0);  chk(cycle_count);
    exp("t5_ar_ins", 0);  chk(instr_count);
    exp("t5_ar_mis", 0);  chk(32'(misalign));
    exp("t5_ar_mcnt", 0); chk(32'(misalign_cnt));
    #1;
    reset = 1'b1;
    tick();
    do_start();
    exp("t5_ar_restart", 1); chk(32'(busy));

    if (q_tag.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_tag.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
